// File: rtl/flipflop_not_toggle_pkg.sv
// flipflop_not_toggle_pkg: shared constants for the toggle divider
package flipflop_not_toggle_pkg;
  localparam logic        TGL_RST_VAL    = 1'b0;
  localparam int unsigned TGL_MIN_STAGES = 1;
endpackage

// File: rtl/flipflop_not_toggle_dff_ar.sv
// dff_ar: 1-bit rising-edge flop with asynchronous active-high reset to a supplied value
module dff_ar (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= rst_val;
    else q <= d;
endmodule

// File: rtl/flipflop_not_toggle.sv
// flipflop_not_toggle: ripple chain of toggle cells dividing CK by 2^STAGES
module flipflop_not_toggle
  import flipflop_not_toggle_pkg::*;
#(
  parameter int unsigned STAGES  = 1,
  parameter logic        RST_VAL = TGL_RST_VAL
) (
  input  logic CK,
  input  logic RB,
  output logic Q,
  output logic D
);
  logic [STAGES-1:0] tgl_q, tgl_d, cell_clk;
  logic arm;
  if (STAGES < TGL_MIN_STAGES) begin : g_bad
    $error("flipflop_not_toggle: STAGES must be >= 1");
  end
  // Release is only honoured once CK has been low, so an edge coinciding with release never toggles.
  always_latch
    if (RB) arm = 1'b0;
    else if (!CK) arm = 1'b1;
  always_comb begin
    tgl_d    = ~tgl_q;
    tgl_d[0] = arm ? ~tgl_q[0] : tgl_q[0];
    cell_clk    = ~(tgl_q << 1);
    cell_clk[0] = CK;
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_cell
    dff_ar u_cell (
      .clk    (cell_clk[i]),
      .rst    (RB),
      .rst_val(RST_VAL),
      .d      (tgl_d[i]),
      .q      (tgl_q[i])
    );
  end
  assign Q = tgl_q[STAGES-1];
  assign D = ~tgl_q[STAGES-1];
endmodule

// File: tb/tb_flipflop_not_toggle.sv
// tb_flipflop_not_toggle: scoreboard bench over four divider configurations
module tb_flipflop_not_toggle;
  typedef struct {
    string name;
    int    idx;
    logic  exp;
  } exp_t;

  logic CK = 1'b0;
  logic rb_a = 1'b1, rb_b = 1'b1, rb_3 = 1'b1, rb_r = 1'b1;
  logic [3:0] qv, dv;
  exp_t sb[$];
  event sample_ev;
  int vectors = 0;
  int miscompares = 0;

  flipflop_not_toggle #(.STAGES(1), .RST_VAL(1'b0)) u_a (.CK(CK), .RB(rb_a), .Q(qv[0]), .D(dv[0]));
  flipflop_not_toggle #(.STAGES(1), .RST_VAL(1'b0)) u_b (.CK(CK), .RB(rb_b), .Q(qv[1]), .D(dv[1]));
  flipflop_not_toggle #(.STAGES(3), .RST_VAL(1'b0)) u_3 (.CK(CK), .RB(rb_3), .Q(qv[2]), .D(dv[2]));
  flipflop_not_toggle #(.STAGES(1), .RST_VAL(1'b1)) u_r (.CK(CK), .RB(rb_r), .Q(qv[3]), .D(dv[3]));

  initial begin
    #0 CK = 1'b1;
    forever #15 CK = ~CK;
  end

  task automatic at(input int t);
    #(t - int'($time));
  endtask

  task automatic chk(input string n, input int idx, input logic e);
    sb.push_back('{n, idx, e});
    -> sample_ev;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (qv[e.idx] !== e.exp || dv[e.idx] !== ~e.exp) begin
          miscompares++;
          $display("FAIL %s at %0t: got Q=%b D=%b, want Q=%b D=%b",
                   e.name, $time, qv[e.idx], dv[e.idx], e.exp, ~e.exp);
        end
      end
    end
  end

  task automatic run_a();
    at(2);   chk("a_reset", 0, 1'b0);
    at(5);   rb_a = 1'b0;
    at(20);  chk("a_before_first_rise", 0, 1'b0);
    at(31);  chk("a_rise30", 0, 1'b1);
    at(61);  chk("a_rise60", 0, 1'b0);
    at(91);  chk("a_rise90", 0, 1'b1);
    at(100); rb_a = 1'b1;
    at(101); chk("a_reset_again", 0, 1'b0);
    at(110);
    @(posedge CK);
    rb_a = 1'b0;
    at(121); chk("a_coincident_hold", 0, 1'b0);
    at(151); chk("a_coincident_next", 0, 1'b1);
    at(181); chk("a_coincident_next2", 0, 1'b0);
  endtask

  task automatic run_b();
    at(2);   chk("b_reset", 1, 1'b0);
    at(5);   rb_b = 1'b0;
    at(31);  chk("b_rise30", 1, 1'b1);
    at(51);  rb_b = 1'b1;
    at(52);  chk("b_midrun_reset", 1, 1'b0);
    at(56);  rb_b = 1'b0;
    at(57);  chk("b_after_release", 1, 1'b0);
    at(61);  chk("b_restart60", 1, 1'b1);
    at(91);  chk("b_rise90", 1, 1'b0);
    at(121); chk("b_rise120", 1, 1'b1);
  endtask

  task automatic run_3();
    at(2); chk("s3_reset", 2, 1'b0);
    at(5); rb_3 = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      at(30 * n + 1);
      chk($sformatf("s3_cycle%0d", n), 2, (n % 8) >= 4);
    end
  endtask

  task automatic run_r();
    at(2);  chk("r_reset", 3, 1'b1);
    at(5);  rb_r = 1'b0;
    at(31); chk("r_rise30", 3, 1'b0);
    at(61); chk("r_rise60", 3, 1'b1);
    at(91); chk("r_rise90", 3, 1'b0);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_3();
      run_r();
    join
    #5;
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
